// File: rtl/decay_pkg.sv
// -----------------------------------------------------------------------------
// decay_pkg
// Shared definitions for the decay sweep scheduler:
//   - decay-rate codes accepted on cfg_decay_rate
//   - sweep FSM state encoding
//   - IEEE-754 single-precision field geometry and a signed-zero helper
// -----------------------------------------------------------------------------
package decay_pkg;

    // Decay-rate codes; any other code leaves the potential unchanged.
    localparam logic [3:0] RATE_DIV1 = 4'b0001;
    localparam logic [3:0] RATE_DIV2 = 4'b0010;
    localparam logic [3:0] RATE_DIV4 = 4'b0100;
    localparam logic [3:0] RATE_DIV8 = 4'b1000;
    localparam logic [3:0] RATE_3Q   = 4'b0011;

    // IEEE-754 single-precision field geometry.
    localparam int         FP_W    = 32;
    localparam int         EXP_W   = 8;
    localparam int         MAN_W   = 23;
    localparam logic [7:0] EXP_MAX = 8'hFF;

    // Sweep sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_DECAY = 3'd2,
        ST_WRITE = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    // Zero of the given sign (used for flush-to-zero results).
    function automatic logic [31:0] fp_signed_zero(input logic sign);
        return {sign, 31'd0};
    endfunction

endpackage

// File: rtl/decay_unit.sv
// -----------------------------------------------------------------------------
// decay_unit
// Purely combinational LIF decay of one IEEE-754 single potential.
//   din  [31:0] : potential read from memory
//   rate [3:0]  : decay code (/1, /2, /4, /8, x0.75, others pass through)
//   dout [31:0] : decayed potential
// Inf/NaN pass unchanged, zero/denormal flush to a signed zero, division is
// an exponent decrement with flush on underflow, x0.75 truncates (no rounding).
// The sign is always preserved.
// -----------------------------------------------------------------------------
module decay_unit
    import decay_pkg::*;
(
    input  logic [31:0] din,
    input  logic [3:0]  rate,
    output logic [31:0] dout
);

    logic             sign_s;
    logic [EXP_W-1:0] exp_s;
    logic [MAN_W-1:0] man_s;
    logic [25:0]      prod_s;
    logic [1:0]       shift_s;
    logic             is_div_s;

    assign sign_s = din[31];
    assign exp_s  = din[30:23];
    assign man_s  = din[22:0];

    // {1,m} * 3 computed as {1,m} + ({1,m} << 1); fits in 26 bits.
    assign prod_s = {2'b00, 1'b1, man_s} + {1'b0, 1'b1, man_s, 1'b0};

    // Decode the rate code into a power-of-two shift amount.
    always_comb begin
        shift_s  = 2'd0;
        is_div_s = 1'b0;
        case (rate)
            RATE_DIV1: begin is_div_s = 1'b1; shift_s = 2'd0; end
            RATE_DIV2: begin is_div_s = 1'b1; shift_s = 2'd1; end
            RATE_DIV4: begin is_div_s = 1'b1; shift_s = 2'd2; end
            RATE_DIV8: begin is_div_s = 1'b1; shift_s = 2'd3; end
            default:   begin is_div_s = 1'b0; shift_s = 2'd0; end
        endcase
    end

    // Apply the selected decay to the unpacked fields.
    always_comb begin
        dout = din;
        if (exp_s == EXP_MAX) begin
            dout = din;
        end else if (exp_s == 8'd0) begin
            dout = fp_signed_zero(sign_s);
        end else if (is_div_s) begin
            if (exp_s <= {6'd0, shift_s}) begin
                dout = fp_signed_zero(sign_s);
            end else begin
                dout = {sign_s, exp_s - {6'd0, shift_s}, man_s};
            end
        end else if (rate == RATE_3Q) begin
            if (prod_s[25]) begin
                // Product carried into bit 25: exponent stays, drop two LSBs.
                dout = {sign_s, exp_s, prod_s[24:2]};
            end else if (exp_s == 8'd1) begin
                // Renormalising would underflow the exponent.
                dout = fp_signed_zero(sign_s);
            end else begin
                dout = {sign_s, exp_s - 8'd1, prod_s[23:1]};
            end
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/decay_sweep_scheduler.sv
// -----------------------------------------------------------------------------
// decay_sweep_scheduler
// Timestep controller that sweeps membrane-potential decay over a neuron
// potential memory, and owns that memory's single port.
//
// Ports:
//   clk, rst_n        : clock (rising edge), synchronous active-low reset
//   tick              : timestep start pulse
//   cfg_decay_rate    : decay code, latched when a sweep starts
//   upd_valid/ready   : potential-adder write handshake (ready only in IDLE)
//   upd_addr/upd_data : adder write target and value
//   mem_en/we/addr/wdata, mem_rdata : potential memory port (1-cycle read)
//   busy              : sweep in progress
//   done              : 1-cycle pulse at sweep end
//   tick_overrun      : 1-cycle pulse when tick arrives during a sweep
//
// Each neuron costs READ -> DECAY -> WRITE (3 cycles).
// Optional macro DECAY_SKIP_ZERO_EN: a potential of +/-0 skips its WRITE,
// so that neuron costs 2 cycles and memory is not touched for it.
// -----------------------------------------------------------------------------
module decay_sweep_scheduler
    import decay_pkg::*;
#(
    parameter int NUM_NEURONS = 1024,
    parameter int ADDR_W      = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic [3:0]        cfg_decay_rate,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic [31:0]       upd_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              tick_overrun
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_NEURONS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t            state_r,   state_s;
    logic [ADDR_W-1:0] addr_r,    addr_s;
    logic [3:0]        rate_r,    rate_s;
    logic [31:0]       decayed_r, decayed_s;
    logic [31:0]       decay_out_s;
    logic              last_s;

    decay_unit u_decay_unit (
        .din  (mem_rdata),
        .rate (rate_r),
        .dout (decay_out_s)
    );

    assign last_s = (addr_r == LAST_ADDR);

    // Sequencer state, neuron address, latched rate and decayed value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            addr_r    <= '0;
            rate_r    <= RATE_DIV1;
            decayed_r <= 32'd0;
        end else begin
            state_r   <= state_s;
            addr_r    <= addr_s;
            rate_r    <= rate_s;
            decayed_r <= decayed_s;
        end
    end

    // Next-state logic and memory-port / handshake outputs.
    always_comb begin
        state_s      = state_r;
        addr_s       = addr_r;
        rate_s       = rate_r;
        decayed_s    = decayed_r;
        upd_ready    = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = 32'd0;
        busy         = 1'b0;
        done         = 1'b0;
        tick_overrun = 1'b0;

        // Everything stays quiet while reset is asserted, so an abandoned
        // sweep cannot issue a partial write in the reset cycle itself.
        if (rst_n) begin
            case (state_r)
                ST_IDLE: begin
                    upd_ready = 1'b1;
                    if (upd_valid) begin
                        mem_en    = 1'b1;
                        mem_we    = 1'b1;
                        mem_addr  = upd_addr;
                        mem_wdata = upd_data;
                    end else begin
                        mem_en    = 1'b0;
                    end
                    // A same-cycle update is still written above.
                    if (tick) begin
                        rate_s  = cfg_decay_rate;
                        addr_s  = '0;
                        state_s = ST_READ;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_READ: begin
                    busy     = 1'b1;
                    mem_en   = 1'b1;
                    mem_addr = addr_r;
                    state_s  = ST_DECAY;
                end
                ST_DECAY: begin
                    busy      = 1'b1;
                    decayed_s = decay_out_s;
`ifdef DECAY_SKIP_ZERO_EN
                    if (mem_rdata[30:0] == 31'd0) begin
                        if (last_s) begin
                            state_s = ST_FIN;
                        end else begin
                            addr_s  = addr_r + ADDR_ONE;
                            state_s = ST_READ;
                        end
                    end else begin
                        state_s = ST_WRITE;
                    end
`else
                    state_s   = ST_WRITE;
`endif
                end
                ST_WRITE: begin
                    busy      = 1'b1;
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = addr_r;
                    mem_wdata = decayed_r;
                    // The address stops at the last neuron; it never wraps.
                    if (last_s) begin
                        state_s = ST_FIN;
                    end else begin
                        addr_s  = addr_r + ADDR_ONE;
                        state_s = ST_READ;
                    end
                end
                ST_FIN: begin
                    busy    = 1'b1;
                    done    = 1'b1;
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase

            // A tick during a sweep is flagged and otherwise ignored.
            if (busy && tick) begin
                tick_overrun = 1'b1;
            end else begin
                tick_overrun = 1'b0;
            end
        end else begin
            state_s = ST_IDLE;
        end
    end

endmodule

// File: tb/tb_decay_sweep_scheduler.sv
// -----------------------------------------------------------------------------
// tb_decay_sweep_scheduler
// Directed bench for decay_sweep_scheduler with NUM_NEURONS=4 and a 4-word
// behavioural potential memory (registered read, 1-cycle latency).
// Cycle 0 of every sweep is the cycle in which tick is driven high.
// -----------------------------------------------------------------------------
module tb_decay_sweep_scheduler;

    localparam int N  = 4;
    localparam int AW = 12;

    logic          clk;
    logic          rst_n;
    logic          tick;
    logic [3:0]    cfg_decay_rate;
    logic          upd_valid;
    logic          upd_ready;
    logic [AW-1:0] upd_addr;
    logic [31:0]   upd_data;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          busy;
    logic          done;
    logic          tick_overrun;

    int n_checks;
    int n_fail;

    // Per-sweep observations.
    int          done_cyc, done_cnt, over_cnt, over_cyc, wr_cnt;
    int          ready_cnt, ready_cyc, rd_first_cyc;
    logic [AW-1:0] rd_first_addr;
    logic [31:0] busy_bits;
    logic        rst_outs;
    logic        upd_taken, rd_seen;
    int          oob_cnt;

    logic [31:0] mem [0:N-1];

    decay_sweep_scheduler #(
        .NUM_NEURONS (N),
        .ADDR_W      (AW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tick           (tick),
        .cfg_decay_rate (cfg_decay_rate),
        .upd_valid      (upd_valid),
        .upd_ready      (upd_ready),
        .upd_addr       (upd_addr),
        .upd_data       (upd_data),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .busy           (busy),
        .done           (done),
        .tick_overrun   (tick_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Potential memory model: write-first not needed, read returns old data.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_addr > AW'(N - 1)) begin
                oob_cnt <= oob_cnt + 1;
            end
            if (mem_we) begin
                mem[mem_addr[1:0]] <= mem_wdata;
            end
            mem_rdata <= mem[mem_addr[1:0]];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Write one potential through the adder path while IDLE.
    task automatic upd_write(input logic [AW-1:0] a, input logic [31:0] d);
        upd_valid = 1'b1;
        upd_addr  = a;
        upd_data  = d;
        @(negedge clk);
        upd_valid = 1'b0;
    endtask

    task automatic preload(input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3);
        upd_write(AW'(0), d0);
        upd_write(AW'(1), d1);
        upd_write(AW'(2), d2);
        upd_write(AW'(3), d3);
    endtask

    // Run ncyc cycles starting with a tick in cycle 0, recording DUT activity.
    task automatic run_sweep(input logic [3:0] rate, input int tick_again,
                             input int upd_start, input logic [AW-1:0] ua,
                             input logic [31:0] ud, input int rst_at, input int ncyc);
        done_cyc = -1; done_cnt = 0; over_cnt = 0; over_cyc = -1; wr_cnt = 0;
        ready_cnt = 0; ready_cyc = -1; rd_first_cyc = -1; rd_first_addr = '1;
        busy_bits = 32'd0; rst_outs = 1'b0; upd_taken = 1'b0; rd_seen = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            tick           = (c == 0) || (c == tick_again);
            cfg_decay_rate = (c == 0) ? rate : 4'b0100;
            upd_valid      = (upd_start >= 0) && (c >= upd_start) && !upd_taken;
            upd_addr       = ua;
            upd_data       = ud;
            rst_n          = !((rst_at >= 0) && (c >= rst_at) && (c <= rst_at + 1));
            #1;
            if (busy && c < 32) busy_bits[c] = 1'b1;
            if (done) begin done_cnt++; done_cyc = c; end
            if (tick_overrun) begin over_cnt++; over_cyc = c; end
            if (mem_en && mem_we) wr_cnt++;
            if (mem_en && !mem_we && !rd_seen) begin
                rd_seen = 1'b1; rd_first_addr = mem_addr; rd_first_cyc = c;
            end
            if (upd_valid && upd_ready) begin
                upd_taken = 1'b1; ready_cnt++; ready_cyc = c;
            end
            if (rst_at >= 0 && c == rst_at + 1) begin
                rst_outs = |{upd_ready, mem_en, mem_we, mem_addr, mem_wdata,
                             busy, done, tick_overrun};
            end
            @(negedge clk);
        end
        tick = 1'b0; upd_valid = 1'b0; rst_n = 1'b1; cfg_decay_rate = 4'b0001;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; oob_cnt = 0;
        rst_n = 1'b0; tick = 1'b0; cfg_decay_rate = 4'b0001;
        upd_valid = 1'b0; upd_addr = '0; upd_data = 32'd0;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset_outputs", 32'(|{upd_ready, mem_en, mem_we, mem_addr,
                 mem_wdata, busy, done, tick_overrun}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("idle_ready", 32'(upd_ready), 32'd1);
        check_eq("idle_busy", 32'(busy), 32'd0);
        @(negedge clk);

        // Rate /2 sweep.
        preload(32'h41deb852, 32'h3F800000, 32'h01000000, 32'h7F800000);
        run_sweep(4'b0010, -1, -1, '0, 32'd0, -1, 15);
        check_eq("div2_mem0", mem[0], 32'h415eb852);
        check_eq("div2_mem1", mem[1], 32'h3F000000);
        check_eq("div2_mem2", mem[2], 32'h00800000);
        check_eq("div2_mem3", mem[3], 32'h7F800000);
        check_eq("div2_done_cyc", 32'(done_cyc), 32'd13);
        check_eq("div2_done_cnt", 32'(done_cnt), 32'd1);
        check_eq("div2_busy", busy_bits, 32'h00003FFE);
        check_eq("div2_writes", 32'(wr_cnt), 32'd4);
        check_eq("div2_first_rd", 32'(rd_first_cyc), 32'd1);

        // x0.75 sweep with held update from cycle 2 and an overrun tick at 5.
        upd_write(AW'(1), 32'h3F800000);
        upd_write(AW'(2), 32'hBFC00000);
        upd_write(AW'(3), 32'h7F800000);
        run_sweep(4'b0011, 5, 2, AW'(3), 32'h12345678, -1, 16);
        check_eq("q3_mem0", mem[0], 32'h41270A3D);
        check_eq("q3_mem1", mem[1], 32'h3F400000);
        check_eq("q3_mem2", mem[2], 32'hBF900000);
        check_eq("q3_upd_mem3", mem[3], 32'h12345678);
        check_eq("q3_ready_cyc", 32'(ready_cyc), 32'd14);
        check_eq("q3_ready_cnt", 32'(ready_cnt), 32'd1);
        check_eq("q3_over_cnt", 32'(over_cnt), 32'd1);
        check_eq("q3_over_cyc", 32'(over_cyc), 32'd5);
        check_eq("q3_done_cyc", 32'(done_cyc), 32'd13);
        check_eq("q3_writes", 32'(wr_cnt), 32'd5);

        // Rate /8 with underflow, negative denormal and Inf.
        preload(32'h01000000, 32'hC1000000, 32'h80400000, 32'h7F800000);
        run_sweep(4'b1000, -1, -1, '0, 32'd0, -1, 15);
        check_eq("div8_mem0", mem[0], 32'h00000000);
        check_eq("div8_mem1", mem[1], 32'hBF800000);
        check_eq("div8_mem2", mem[2], 32'h80000000);
        check_eq("div8_mem3", mem[3], 32'h7F800000);

        // Reset in cycle 7 (held through cycle 8) abandons the sweep.
        preload(32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000);
        run_sweep(4'b0010, -1, -1, '0, 32'd0, 7, 15);
        check_eq("rst_outs_zero", 32'(rst_outs), 32'd0);
        check_eq("rst_no_done", 32'(done_cnt), 32'd0);
        check_eq("rst_writes", 32'(wr_cnt), 32'd2);
        check_eq("rst_mem1", mem[1], 32'h3F800000);
        check_eq("rst_mem2", mem[2], 32'h40000000);
        run_sweep(4'b0010, -1, -1, '0, 32'd0, -1, 15);
        check_eq("restart_rd_addr", 32'(rd_first_addr), 32'd0);
        check_eq("restart_rd_cyc", 32'(rd_first_cyc), 32'd1);
        check_eq("restart_done", 32'(done_cyc), 32'd13);
        check_eq("restart_mem0", mem[0], 32'h3F000000);
        check_eq("restart_mem3", mem[3], 32'h3F800000);

        // All-zero potentials.
        preload(32'h0, 32'h80000000, 32'h0, 32'h0);
        run_sweep(4'b0010, -1, -1, '0, 32'd0, -1, 15);
`ifdef DECAY_SKIP_ZERO_EN
        check_eq("zero_done_cyc", 32'(done_cyc), 32'd9);
        check_eq("zero_writes", 32'(wr_cnt), 32'd0);
        check_eq("zero_busy", busy_bits, 32'h000003FE);
`else
        check_eq("zero_done_cyc", 32'(done_cyc), 32'd13);
        check_eq("zero_writes", 32'(wr_cnt), 32'd4);
        check_eq("zero_busy", busy_bits, 32'h00003FFE);
`endif
        check_eq("zero_mem1", mem[1], 32'h80000000);
        check_eq("no_oob_access", 32'(oob_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decay_sweep_scheduler.md
Name: decay_sweep_scheduler

Overview:
- Timestep controller for membrane-potential decay across a neuron potential memory.
- On each timestep tick it walks neurons 0..NUM_NEURONS-1: read IEEE-754 single potential, apply LIF decay, write back.
- Owns the single potential-memory port and arbitrates it against the potential-adder update stream; the adder is stalled while a sweep runs.
- Sits between the potential adder and potential memory, replacing the level-triggered clear/set decay with a clocked sequencer.

Parameters:
- NUM_NEURONS, 1024, neurons swept per tick (1..2^ADDR_W).
- ADDR_W, 12, neuron address width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- tick  in  1  timestep start pulse (1 cycle).
- cfg_decay_rate  in  4  decay code: 0001 /1, 0010 /2, 0100 /4, 1000 /8, 0011 x0.75; other codes pass through. Sampled at sweep start.
- upd_valid  in  1  adder write request.
- upd_ready  out  1  adder write accepted this cycle.
- upd_addr  in  ADDR_W  adder target neuron.
- upd_data  in  32  new potential from the adder.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid 1 cycle after a read.
- busy  out  1  sweep in progress.
- done  out  1  1-cycle pulse at sweep end.
- tick_overrun  out  1  1-cycle pulse: tick arrived while busy.

Behaviour:
- Reset (rst_n=0 at an edge): FSM->IDLE, all outputs 0, address counter 0, latched rate 0001. Reset mid-sweep abandons the sweep with no partial write afterwards and no done.
- FSM states: IDLE, READ, DECAY, WRITE, FIN.
- IDLE:
  - upd_ready=1 combinationally.
  - upd_valid=1 -> mem_en=1, mem_we=1, mem_addr=upd_addr, mem_wdata=upd_data in the same cycle.
  - tick=1 -> latch cfg_decay_rate, addr=0, go to READ. On a simultaneous tick and upd_valid, the update is still accepted and written that cycle.
- READ: mem_en=1, mem_we=0, mem_addr=addr -> DECAY.
- DECAY: register decay(mem_rdata) -> WRITE.
- WRITE: mem_en=1, mem_we=1, mem_addr=addr, mem_wdata=decayed value. If addr==NUM_NEURONS-1 go to FIN, else addr+1 and go to READ. No wrap past NUM_NEURONS-1.
- FIN: done=1 -> IDLE.
- busy=1 in READ, DECAY, WRITE and FIN. upd_ready=0 whenever busy. Adder must hold upd_valid/addr/data until ready.
- Latency: tick seen in cycle 0; neuron k is read in cycle 3k+1 and written in cycle 3k+3; done in cycle 3N+1; IDLE again in cycle 3N+2.
- tick while busy: ignored, tick_overrun=1 for that cycle, sweep continues unchanged.
- Decay arithmetic (fields s, e[7:0], m[22:0]):
  - e==255 (Inf/NaN): pass unchanged.
  - e==0 (zero/denormal): output {s,31'b0}.
  - /2^k (k=0..3): if e<=k, output {s,31'b0}; else {s, e-k, m}.
  - x0.75: P = {1,m}*3 (26 bits). If P[25]=1: {s, e, P[24:2]}; else {s, e-1, P[23:1]}. Truncation only, no rounding. If e-1 underflows (e==1 and P[25]=0), output {s,31'b0}.
  - Sign is always preserved.

Optional Feature:
- Macro: DECAY_SKIP_ZERO_EN.
- Defined: in DECAY, a value with e==0 and m==0 skips WRITE. Go to READ at addr+1, or to FIN if it is the last neuron; that neuron costs 2 cycles. Memory is not written.
- Undefined: every neuron is written back, fixed 3 cycles per neuron.

Decomposition:
- Package decay_pkg: decay-rate code localparams (RATE_DIV1/2/4/8, RATE_3Q), FSM state enum, FP field widths.
- Sub-module decay_unit: purely combinational 32-bit in, 4-bit rate, 32-bit out, implementing the arithmetic above; instantiated once in DECAY.

Test Plan:
- Rate 0010, mem[0]=0x41deb852, N=4, tick -> mem[0]=0x415eb852; done at cycle 13; busy high in cycles 1-13.
- Rate 0011, mem[1]=0x3F800000 -> 0x3F400000. Rate 0011, 0xBFC00000 -> 0xBF900000.
- Rate 1000, mem[2]=0x01000000 (e=2) -> 0x00000000. mem[3]=0x7F800000 -> unchanged.
- upd_valid held from cycle 2 of a sweep -> upd_ready=0 until the IDLE cycle 3N+2, then the write is issued once. Tick in cycle 5 -> tick_overrun pulse, done still at 3N+1.
- rst_n=0 in cycle 7 of a sweep -> next cycle all outputs 0, no mem write, no done; new tick restarts at addr 0.
- DECAY_SKIP_ZERO_EN defined, N=4, all potentials zero -> no mem_we during sweep, done at cycle 9.
